vga_frame_scheduler: RTL
========================

Name: vga_frame_scheduler

Overview:
- Pixel-domain controller that sequences the VGA scan-out path: SDRAM fetcher, async pixel FIFO and timing generator.
- Holds the timing generator off until the FIFO is primed, and selects the framebuffer base address with page flips applied only at frame boundaries.
- Detects FIFO underflow during visible pixels and recovers by halting the fetcher, draining the FIFO and re-priming.
- Sits between the timing generator / FIFO read side and the Wishbone fetcher control inputs.

Parameters:
ADDR_W, 32, width of framebuffer byte addresses
DEFAULT_BASE, 32'h0000_0000, base_addr value after reset
HOLD_CYCLES, 8, consecutive empty cycles required in DRAIN before refill (covers fetch-domain sync latency and in-flight acks)
FCNT_W, 16, frame counter width
UCNT_W, 8, underflow counter width

Ports:
pixel_clk  in  1  pixel clock; all logic on rising edge
pixel_rst  in  1  asynchronous, active-high reset
fifo_wfull  in  1  FIFO full flag, write (Wishbone) clock domain; unsynchronised
fifo_rempty  in  1  FIFO empty flag, pixel domain
blank  in  1  timing generator display-enable; 1 = visible pixel, FIFO read this cycle
vs  in  1  vertical sync from timing generator, active low
flip_req  in  1  page-flip request from producer; level, held until flip_ack
flip_base  in  ADDR_W  requested framebuffer base; stable while flip_req=1
timing_en  out  1  1 = timing generator runs; 0 = timing counters held at 0
fetch_hold  out  1  1 = fetcher stops, deasserts cyc, reloads address from base_addr
drain_rd  out  1  forced FIFO read strobe, ORed with blank at the FIFO read port
base_addr  out  ADDR_W  current framebuffer base; bits [1:0] always 0
flip_ack  out  1  one-cycle pulse; flip_base accepted
frame_cnt  out  FCNT_W  completed frames in RUN; wraps
underflow_cnt  out  UCNT_W  underflow events; saturates at all-ones
state_o  out  2  current state encoding, for debug

Behaviour:
- fifo_wfull passes through a 2-flop synchroniser (reset 0) to give full_s.
- vs_q is a registered copy of vs (reset 1). frame_edge = vs_q & ~vs, i.e. the VS falling edge.
- States: DRAIN=0, FILL=1, RUN=2. Reset state is DRAIN.
- Reset values: timing_en 0, fetch_hold 1, drain_rd 0, base_addr DEFAULT_BASE with [1:0] forced 0, flip_ack 0, frame_cnt 0, underflow_cnt 0, empty-run counter 0.
- Output decode is combinational from the state register:
  - timing_en = (state==RUN)
  - fetch_hold = (state==DRAIN)
  - drain_rd = (state==DRAIN) & ~fifo_rempty
- DRAIN:
  - Empty-run counter increments while fifo_rempty=1 (saturating at HOLD_CYCLES) and clears to 0 whenever fifo_rempty=0.
  - When counter == HOLD_CYCLES, go to FILL.
  - On that transition edge, if flip_req=1: base_addr <= {flip_base[ADDR_W-1:2],2'b00} and flip_ack=1 for one cycle. The fetcher therefore restarts from the new base.
- FILL: wait for full_s=1, then go to RUN. blank is ignored in FILL.
- RUN:
  - On frame_edge: frame_cnt+1 (wraps). If flip_req=1, base_addr updates and flip_ack pulses; both are registered, visible 1 cycle after vs is sampled low.
  - Underflow = blank & fifo_rempty. On underflow: go to DRAIN, underflow_cnt+1 (saturating), empty-run counter cleared.
- Simultaneous underflow and frame_edge: underflow wins. No frame count, no flip; a pending flip is taken at the DRAIN->FILL transition instead.
- flip_req already high and unacknowledged is sampled only at the acceptance points above. After an ack, a request still high on the next cycle is not re-accepted until the next acceptance point.
- flip_ack is never asserted in FILL.
- full_s dropping in RUN has no effect.
- pixel_rst mid-operation: immediate return to DRAIN with all reset values. Any pending flip is lost and the producer must re-request.
- Latency:
  - fifo_wfull rising, first sampled at edge N, gives timing_en=1 after edge N+2 (two sync flops; state register at N+2).
  - Underflow sampled at edge M gives timing_en=0 and fetch_hold=1 after edge M.

Decomposition:
- Package vga_pkg:
  - State enum vga_sched_state_t {DRAIN, FILL, RUN}, 2-bit.
  - DEFAULT_BASE and HOLD_CYCLES defaults.
  - Shared frame geometry constants (HDISP/VDISP/porches), so the timing generator and this block agree.
- Sub-module bit_sync: parameterised N-stage single-bit synchroniser with async active-high reset and reset value 0; used for fifo_wfull.

Test Plan:
- Reset with FIFO empty; hold fifo_rempty=1 for 8 cycles -> state FILL after the 8th, fetch_hold falls. Raise fifo_wfull -> timing_en=1 exactly 3 edges later, frame_cnt=0.
- In RUN, flip_req=1 with flip_base=32'h0010_0003 mid-frame -> base_addr unchanged until vs falls. Then base_addr=32'h0010_0000, flip_ack high one cycle, frame_cnt=1.
- In RUN, force fifo_rempty=1 while blank=1 -> next edge state DRAIN, timing_en=0, fetch_hold=1, underflow_cnt=1, drain_rd=0. Present 5 non-empty cycles -> drain_rd=1 for those 5 cycles, and the empty-run counter restarts from 0 afterwards.
- Assert underflow and vs falling edge in the same cycle with flip_req=1 -> frame_cnt unchanged, no ack. flip_ack pulses at the DRAIN->FILL transition with the new base_addr.
- Inject 300 underflows -> underflow_cnt saturates at 8'hFF. Run 65536 frames -> frame_cnt wraps to 0.
- Assert pixel_rst during FILL with flip_req pending -> all outputs at reset values asynchronously. After release the block restarts in DRAIN and the flip is acknowledged at the first DRAIN->FILL transition.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA scan-out path: scheduler state encoding,
// reset defaults and the 640x480@60 frame geometry used by the timing generator.
package vga_pkg;

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } vga_sched_state_t;

    localparam logic [31:0] DEFAULT_BASE_C = 32'h0000_0000;
    localparam int          HOLD_CYCLES_C  = 8;

    // 640x480 frame geometry; the timing generator counts against these
    localparam int HDISP  = 640;
    localparam int HFP    = 16;
    localparam int HSYNC  = 96;
    localparam int HBP    = 48;
    localparam int HTOTAL = HDISP + HFP + HSYNC + HBP;
    localparam int VDISP  = 480;
    localparam int VFP    = 10;
    localparam int VSYNC  = 2;
    localparam int VBP    = 33;
    localparam int VTOTAL = VDISP + VFP + VSYNC + VBP;

endpackage

// File: rtl/vga_frame_scheduler_if.sv
// Signal bundle between the scheduler and its surroundings (timing generator,
// pixel FIFO flags, page-flip producer and fetcher control).
interface vga_frame_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int FCNT_W = 16,
    parameter int UCNT_W = 8
);
    logic              fifo_wfull;
    logic              fifo_rempty;
    logic              blank;
    logic              vs;
    logic              flip_req;
    logic [ADDR_W-1:0] flip_base;
    logic              timing_en;
    logic              fetch_hold;
    logic              drain_rd;
    logic [ADDR_W-1:0] base_addr;
    logic              flip_ack;
    logic [FCNT_W-1:0] frame_cnt;
    logic [UCNT_W-1:0] underflow_cnt;
    logic [1:0]        state_o;

    modport master (
        output fifo_wfull, fifo_rempty, blank, vs, flip_req, flip_base,
        input  timing_en, fetch_hold, drain_rd, base_addr, flip_ack,
               frame_cnt, underflow_cnt, state_o
    );

    modport slave (
        input  fifo_wfull, fifo_rempty, blank, vs, flip_req, flip_base,
        output timing_en, fetch_hold, drain_rd, base_addr, flip_ack,
               frame_cnt, underflow_cnt, state_o
    );
endinterface

// File: rtl/bit_sync.sv
// N-stage single-bit synchroniser, asynchronous active-high reset to 0.
// STAGES must be at least 2.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_r;

    // shift chain; the first flop is the only one allowed to go metastable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];
endmodule

// File: rtl/vga_frame_scheduler.sv
// Pixel-domain scan-out sequencer: primes the FIFO before releasing timing, applies
// page flips only at frame boundaries, and recovers from underflow by drain/re-prime.
module vga_frame_scheduler
    import vga_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] DEFAULT_BASE = ADDR_W'(DEFAULT_BASE_C),
    parameter int                HOLD_CYCLES  = HOLD_CYCLES_C,
    parameter int                FCNT_W       = 16,
    parameter int                UCNT_W       = 8
) (
    input  logic                  pixel_clk,
    input  logic                  pixel_rst,
    vga_frame_scheduler_if.slave  bus
);
    localparam int                ECNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [ECNT_W-1:0] HOLD_E     = ECNT_W'(HOLD_CYCLES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [UCNT_W-1:0] UCNT_MAX   = {UCNT_W{1'b1}};

    vga_sched_state_t  state_r;
    logic              vs_r;
    logic [ECNT_W-1:0] empty_cnt_r;
    logic [ECNT_W-1:0] empty_cnt_nxt_s;
    logic [ADDR_W-1:0] base_r;
    logic              flip_ack_r;
    logic [FCNT_W-1:0] frame_cnt_r;
    logic [UCNT_W-1:0] ucnt_r;
    logic              full_s;
    logic              frame_edge_s;
    logic              underflow_s;
    logic              timing_en_s;
    logic              fetch_hold_s;
    logic              drain_rd_s;

    bit_sync #(.STAGES(2)) u_full_sync (
        .clk (pixel_clk),
        .rst (pixel_rst),
        .d   (bus.fifo_wfull),
        .q   (full_s)
    );

    // event detection and the saturating empty-run count for DRAIN
    always_comb begin
        frame_edge_s    = vs_r & ~bus.vs;
        underflow_s     = bus.blank & bus.fifo_rempty;
        empty_cnt_nxt_s = '0;
        if (bus.fifo_rempty) begin
            if (empty_cnt_r == HOLD_E) begin
                empty_cnt_nxt_s = HOLD_E;
            end else begin
                empty_cnt_nxt_s = empty_cnt_r + ECNT_W'(1);
            end
        end else begin
            empty_cnt_nxt_s = '0;
        end
    end

    // control FSM with base address, flip handshake and event counters
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state_r     <= DRAIN;
            vs_r        <= 1'b1;
            empty_cnt_r <= '0;
            base_r      <= DEFAULT_BASE & ALIGN_MASK;
            flip_ack_r  <= 1'b0;
            frame_cnt_r <= '0;
            ucnt_r      <= '0;
        end else begin
            vs_r       <= bus.vs;
            flip_ack_r <= 1'b0;
            case (state_r)
                DRAIN: begin
                    empty_cnt_r <= empty_cnt_nxt_s;
                    if (empty_cnt_nxt_s == HOLD_E) begin
                        state_r <= FILL;
                        if (bus.flip_req) begin
                            base_r     <= bus.flip_base & ALIGN_MASK;
                            flip_ack_r <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    empty_cnt_r <= '0;
                    if (full_s) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    empty_cnt_r <= '0;
                    // underflow takes priority; a pending flip waits for DRAIN->FILL
                    if (underflow_s) begin
                        state_r <= DRAIN;
                        if (ucnt_r != UCNT_MAX) begin
                            ucnt_r <= ucnt_r + UCNT_W'(1);
                        end
                    end else if (frame_edge_s) begin
                        frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
                        if (bus.flip_req) begin
                            base_r     <= bus.flip_base & ALIGN_MASK;
                            flip_ack_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= DRAIN;
                    empty_cnt_r <= '0;
                end
            endcase
        end
    end

    // output decode straight from the state register
    always_comb begin
        timing_en_s  = 1'b0;
        fetch_hold_s = 1'b0;
        drain_rd_s   = 1'b0;
        case (state_r)
            DRAIN: begin
                fetch_hold_s = 1'b1;
                drain_rd_s   = ~bus.fifo_rempty;
            end
            FILL: begin
                fetch_hold_s = 1'b0;
            end
            RUN: begin
                timing_en_s = 1'b1;
            end
            default: begin
                fetch_hold_s = 1'b1;
            end
        endcase
    end

    assign bus.timing_en     = timing_en_s;
    assign bus.fetch_hold    = fetch_hold_s;
    assign bus.drain_rd      = drain_rd_s;
    assign bus.base_addr     = base_r;
    assign bus.flip_ack      = flip_ack_r;
    assign bus.frame_cnt     = frame_cnt_r;
    assign bus.underflow_cnt = ucnt_r;
    assign bus.state_o       = state_r;
endmodule
